mlp_seq_engine: RTL

- Second-generation two-layer MLP accelerator behind the same simplified Avalon-MM slave style as the existing MLP IP.
- One shared signed MAC is time-multiplexed over all neurons, neuron by neuron.
- Adds fixed-point scaling with saturation, a per-layer activation mode, pointer-based random access to inputs, weights and outputs, and sticky status/error flags.
- Sits between the Nios/HPS bus bridge and nothing else; it is a leaf IP.

---
 rtl/mlp_seq_engine_if.sv | 12 +
 rtl/mlp_seq_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_engine_if.sv
// rtl/mlp_seq_engine_if.sv - register bus interface for mlp_seq_engine
interface mlp_seq_engine_if;
  logic        write_en;
  logic        read_en;
  logic [2:0]  addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output write_en, read_en, addr, writedata, input readdata, irq);
  modport slave  (input write_en, read_en, addr, writedata, output readdata, irq);
endinterface

// File: rtl/mlp_seq_engine.sv
// rtl/mlp_seq_engine.sv - two-layer MLP with one shared signed MAC, neuron by neuron
module mlp_seq_engine #(
  parameter int N_INPUTS  = 4,
  parameter int N_HIDDEN  = 8,
  parameter int N_OUTPUT  = 4,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  mlp_seq_engine_if.slave bus
);
  localparam int W0_DEPTH = N_HIDDEN * (N_INPUTS + 1);
  localparam int W1_DEPTH = N_OUTPUT * (N_HIDDEN + 1);
  localparam int A0 = $clog2(W0_DEPTH);
  localparam int A1 = $clog2(W1_DEPTH);
  localparam logic [7:0] FAN0 = 8'(N_INPUTS);
  localparam logic [7:0] FAN1 = 8'(N_HIDDEN);
  localparam logic [9:0] ROW0 = 10'(N_INPUTS + 1);
  localparam logic [9:0] ROW1 = 10'(N_HIDDEN + 1);
  localparam logic signed [MAC_WIDTH-1:0] BIAS_ONE = MAC_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [MAC_WIDTH-1:0] OUT_MAX  = MAC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [MAC_WIDTH-1:0] OUT_MIN  = -OUT_MAX - MAC_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, L0_MAC, L0_WB, L1_MAC, L1_WB, FIN} state_t;
  state_t state_q, state_d;

  logic signed [IN_WIDTH-1:0]  x_q [N_INPUTS];
  logic signed [OUT_WIDTH-1:0] h_q [N_HIDDEN];
  logic signed [OUT_WIDTH-1:0] y_q [N_OUTPUT];
  logic signed [WGT_WIDTH-1:0] w0_mem [W0_DEPTH];
  logic signed [WGT_WIDTH-1:0] w1_mem [W1_DEPTH];

  logic [9:0]  ptr_q;
  logic        run_q, done_q, irq_en_q, layer_sel_q, sat_q, err_q;
  logic [1:0]  act0_q, act1_q;
  logic [31:0] readdata_q;
  logic signed [MAC_WIDTH-1:0] acc_q;
  logic [7:0]  k_q, j_q;

  logic wr_ctrl, wr_in, wr_wgt, wr_ptr, rd_out, busy, start, layer1;
  logic wgt_in_range;
  logic [9:0] w_addr;
  logic signed [MAC_WIDTH-1:0] op_ext, w_ext, prod, shifted;
  logic signed [OUT_WIDTH-1:0] clip, act_res, y_rd;
  logic [1:0] act_mode;
  logic sat_hit;
  logic unused_wd;

  assign wr_ctrl = bus.write_en && bus.addr == 3'd0;
  assign wr_in   = bus.write_en && bus.addr == 3'd2;
  assign wr_wgt  = bus.write_en && bus.addr == 3'd3;
  assign wr_ptr  = bus.write_en && bus.addr == 3'd5;
  assign rd_out  = bus.read_en  && bus.addr == 3'd4;
  assign busy    = state_q != IDLE;
  assign start   = wr_ctrl && bus.writedata[0] && !busy;
  assign layer1  = state_q == L1_MAC || state_q == L1_WB;
  assign wgt_in_range = layer_sel_q ? (ptr_q < 10'(W1_DEPTH)) : (ptr_q < 10'(W0_DEPTH));
  assign bus.readdata = readdata_q;
  assign bus.irq      = done_q & irq_en_q;
  assign unused_wd    = ^bus.writedata[31:16];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = L0_MAC;
      L0_MAC: if (k_q == FAN0) state_d = L0_WB;
      L0_WB:  state_d = (j_q == 8'(N_HIDDEN - 1)) ? L1_MAC : L0_MAC;
      L1_MAC: if (k_q == FAN1) state_d = L1_WB;
      L1_WB:  state_d = (j_q == 8'(N_OUTPUT - 1)) ? FIN : L1_MAC;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand k=0 is the implicit bias input (1.0 in Q format).
  always_comb begin
    op_ext = BIAS_ONE;
    for (int i = 0; i < N_INPUTS; i++)
      if (!layer1 && k_q == 8'(i + 1)) op_ext = MAC_WIDTH'($signed(x_q[i]));
    for (int i = 0; i < N_HIDDEN; i++)
      if (layer1 && k_q == 8'(i + 1)) op_ext = MAC_WIDTH'($signed(h_q[i]));
    w_addr = layer1 ? (10'(j_q) * ROW1 + 10'(k_q)) : (10'(j_q) * ROW0 + 10'(k_q));
    w_ext  = layer1 ? MAC_WIDTH'($signed(w1_mem[A1'(w_addr)]))
                    : MAC_WIDTH'($signed(w0_mem[A0'(w_addr)]));
    prod    = op_ext * w_ext;
    shifted = acc_q >>> FRAC_BITS;
    sat_hit = 1'b0;
    clip    = OUT_WIDTH'(shifted);
    if (shifted > OUT_MAX) begin
      clip = OUT_WIDTH'(OUT_MAX);
      sat_hit = 1'b1;
    end else if (shifted < OUT_MIN) begin
      clip = OUT_WIDTH'(OUT_MIN);
      sat_hit = 1'b1;
    end
    act_mode = layer1 ? act1_q : act0_q;
    act_res  = clip;
    if (clip < 0) begin
      case (act_mode)
        2'b01, 2'b11: act_res = '0;
        2'b10:        act_res = clip >>> 3;
        default:      act_res = clip;
      endcase
    end
    y_rd = '0;
    for (int i = 0; i < N_OUTPUT; i++)
      if (ptr_q == 10'(i)) y_rd = y_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_wgt && !busy && wgt_in_range) begin
      if (layer_sel_q) w1_mem[A1'(ptr_q)] <= bus.writedata[WGT_WIDTH-1:0];
      else             w0_mem[A0'(ptr_q)] <= bus.writedata[WGT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0; run_q <= 1'b0; done_q <= 1'b0; irq_en_q <= 1'b0;
      layer_sel_q <= 1'b0; sat_q <= 1'b0; err_q <= 1'b0;
      act0_q <= '0; act1_q <= '0; readdata_q <= '0;
      acc_q <= '0; k_q <= '0; j_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) x_q[i] <= '0;
      for (int i = 0; i < N_HIDDEN; i++) h_q[i] <= '0;
      for (int i = 0; i < N_OUTPUT; i++) y_q[i] <= '0;
    end else begin
      run_q <= 1'b0;
      if (wr_ctrl) begin
        irq_en_q    <= bus.writedata[2];
        layer_sel_q <= bus.writedata[3];
        act0_q      <= bus.writedata[5:4];
        act1_q      <= bus.writedata[7:6];
        if (bus.writedata[1]) done_q <= 1'b0;
        if (bus.writedata[8]) err_q  <= 1'b0;
        if (bus.writedata[0] && busy) err_q <= 1'b1;
      end
      if (start) begin
        run_q <= 1'b1; sat_q <= 1'b0; done_q <= 1'b0;
        k_q <= '0; j_q <= '0;
      end

      if (wr_ptr) ptr_q <= bus.writedata[9:0];
      else if (wr_in || wr_wgt || rd_out) ptr_q <= ptr_q + 10'd1;
      if (wr_in && (busy || ptr_q >= 10'(N_INPUTS))) err_q <= 1'b1;
      if (wr_wgt && (busy || !wgt_in_range)) err_q <= 1'b1;
      if (rd_out && ptr_q >= 10'(N_OUTPUT)) err_q <= 1'b1;
      for (int i = 0; i < N_INPUTS; i++)
        if (wr_in && !busy && ptr_q == 10'(i)) x_q[i] <= bus.writedata[IN_WIDTH-1:0];

      case (bus.addr)
        3'd0:    readdata_q <= {24'd0, act1_q, act0_q, layer_sel_q, irq_en_q, done_q, run_q};
        3'd1:    readdata_q <= {29'd0, err_q, sat_q, busy};
        3'd4:    readdata_q <= 32'($signed(y_rd));
        3'd5:    readdata_q <= {22'd0, ptr_q};
        default: readdata_q <= '0;
      endcase

      case (state_q)
        L0_MAC, L1_MAC: begin
          acc_q <= (k_q == 8'd0) ? prod : acc_q + prod;
          k_q   <= k_q + 8'd1;
        end
        L0_WB, L1_WB: begin
          if (sat_hit) sat_q <= 1'b1;
          for (int i = 0; i < N_HIDDEN; i++)
            if (state_q == L0_WB && j_q == 8'(i)) h_q[i] <= act_res;
          for (int i = 0; i < N_OUTPUT; i++)
            if (state_q == L1_WB && j_q == 8'(i)) y_q[i] <= act_res;
          k_q <= '0;
          if ((state_q == L0_WB && j_q == 8'(N_HIDDEN - 1)) ||
              (state_q == L1_WB && j_q == 8'(N_OUTPUT - 1)))
            j_q <= '0;
          else
            j_q <= j_q + 8'd1;
        end
        FIN: done_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
